phys_reg_free_list: RTL and testbench
=====================================

// Module: phys_reg_free_list
// PURPOSE
//  Parametrised circular free list of physical register tags for the rename stage.
//  Hands out one free physical register per cycle to rename, and takes back one old mapping per cycle from ROB commit.
//  Holds a committed-head pointer, so a pipeline flush returns every speculative allocation in one cycle.
//  Sits between rename (allocate side) and ROB commit (free/commit side); sized from the CPU parameter package.
// PARAMETERS
//  PHY_REGS    64                    total physical registers
//  ARCH_REGS   32                    architectural registers; tags 0..ARCH_REGS-1 are mapped at reset
//  DEPTH       PHY_REGS-ARCH_REGS    free-list entries (need not be a power of 2)
//  PHY_WIDTH   $clog2(PHY_REGS)      tag width
//  CNT_WIDTH   $clog2(DEPTH+1)       count width
// PORTS
//  clk           in   1          clock, rising edge
//  rst_n         in   1          synchronous active-low reset
//  alloc_req     in   1          rename requests one physical register this cycle
//  alloc_valid   out  1          grant: alloc_preg is valid and is popped at this edge
//  alloc_preg    out  PHY_WIDTH  tag at the speculative head
//  free_valid    in   1          commit returns an old physical register
//  free_preg     in   PHY_WIDTH  tag being returned
//  commit_alloc  in   1          a committing instruction had a destination; advances the committed head
//  flush         in   1          mispredict/exception recovery
//  free_count    out  CNT_WIDTH  speculative number of free entries
//  empty         out  1          free_count == 0
//  err_overflow  out  1          sticky: a free arrived while free_count == DEPTH
// BEHAVIOUR
//  State
//   - fifo[DEPTH] of tags
//   - head, commit_head, tail: pointers mod DEPTH, wrap at DEPTH-1 -> 0
//   - spec_cnt (drives free_count) and commit_cnt, both CNT_WIDTH
//  Reset (rst_n==0 at a rising edge)
//   - fifo[i] = ARCH_REGS+i; head = commit_head = tail = 0
//   - spec_cnt = commit_cnt = DEPTH; err_overflow = 0
//   - Outputs after reset: alloc_preg = ARCH_REGS, empty = 0, alloc_valid = alloc_req
//   - Reset mid-operation discards everything in flight.
//  Allocate (combinational grant, pop at edge)
//   - alloc_valid = alloc_req & ~empty & ~flush; alloc_preg = fifo[head] always
//   - On grant: head++ and spec_cnt-- at the clock edge.
//  Free
//   - On free_valid: fifo[tail] <= free_preg; tail++; spec_cnt++ and commit_cnt++.
//   - No same-cycle bypass: with empty==1 and a free in the same cycle, alloc_valid stays 0 and the tag is granted next cycle.
//   - Free with spec_cnt==DEPTH: sets err_overflow; write and increment are suppressed.
//  Commit
//   - On commit_alloc: commit_head++; commit_cnt--.
//   - Never exceeds the allocations already made; the ROB guarantees this.
//  Flush (highest priority over alloc; no grant in the flush cycle)
//   - head <= commit_head_next (commit_head advanced by this cycle's commit_alloc).
//   - spec_cnt <= commit_cnt_next (includes this cycle's free and commit).
//   - Free and commit in the flush cycle are still applied.
//   - Next cycle, alloc_preg = fifo[commit_head_next].
//  Same-cycle grant + free: spec_cnt is unchanged; both pointers advance.
//  Counter arithmetic is width-exact; pointer increments use compare-to-DEPTH-1 wrap, not power-of-2 masking.
// TESTING (PHY_REGS=64, ARCH_REGS=32, DEPTH=32)
//  1 reset, alloc_req for 3 cycles -> alloc_preg 32,33,34 with alloc_valid=1; free_count=29
//  2 32 grants, req held on the 33rd -> empty=1, alloc_valid=0, free_count=0
//  3 from empty: free_valid with preg 5 plus alloc_req in the same cycle -> alloc_valid=0; next cycle alloc_valid=1, alloc_preg=5
//  4 after reset: grant 32..35, commit_alloc for 1 cycle, then flush -> next alloc_preg=33, free_count=31
//  5 wrap: drain all 32, free 7 then 9 -> grants return 7 then 9; tail and head wrap 31->0
//  6 rst_n=0 during a stream of grants -> next cycle free_count=32, alloc_preg=32, err_overflow=0; free at full sets err_overflow=1

Source files
------------

// File: rtl/phys_reg_free_list_if.sv
// rtl/phys_reg_free_list_if.sv - rename/commit side bundle for the physical register free list
interface phys_reg_free_list_if #(
  parameter int PHY_WIDTH = 6,
  parameter int CNT_WIDTH = 6
);
  logic                 alloc_req;
  logic                 alloc_valid;
  logic [PHY_WIDTH-1:0] alloc_preg;
  logic                 free_valid;
  logic [PHY_WIDTH-1:0] free_preg;
  logic                 commit_alloc;
  logic                 flush;
  logic [CNT_WIDTH-1:0] free_count;
  logic                 empty;
  logic                 err_overflow;

  modport master (
    output alloc_req, free_valid, free_preg, commit_alloc, flush,
    input  alloc_valid, alloc_preg, free_count, empty, err_overflow
  );

  modport slave (
    input  alloc_req, free_valid, free_preg, commit_alloc, flush,
    output alloc_valid, alloc_preg, free_count, empty, err_overflow
  );
endinterface

// File: rtl/phys_reg_free_list.sv
// rtl/phys_reg_free_list.sv - circular free list of physical register tags with flush recovery
module phys_reg_free_list #(
  parameter int PHY_REGS  = 64,
  parameter int ARCH_REGS = 32,
  parameter int DEPTH     = PHY_REGS - ARCH_REGS,
  parameter int PHY_WIDTH = $clog2(PHY_REGS),
  parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input logic                 clk,
  input logic                 rst_n,
  phys_reg_free_list_if.slave fl
);
  localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_WIDTH-1:0] PTR_LAST = PTR_WIDTH'(DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic [PHY_WIDTH-1:0] fifo [DEPTH];
  logic [PTR_WIDTH-1:0] head, commit_head, tail;
  logic [CNT_WIDTH-1:0] spec_cnt, commit_cnt;
  logic                 err_q;

  logic                 grant, do_free, overflow;
  logic [PTR_WIDTH-1:0] head_next, commit_head_next, tail_next;
  logic [CNT_WIDTH-1:0] spec_cnt_next, commit_cnt_next;

  // Depth need not be a power of two, so wrap by compare rather than by masking.
  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_WIDTH'(1);
  endfunction

  // Flush wins over allocation; a free into a full list is dropped and flagged.
  assign grant    = fl.alloc_req & (spec_cnt != '0) & ~fl.flush;
  assign overflow = fl.free_valid & (spec_cnt == CNT_FULL);
  assign do_free  = fl.free_valid & ~overflow;

  assign fl.alloc_valid  = grant;
  assign fl.alloc_preg   = fifo[head];
  assign fl.free_count   = spec_cnt;
  assign fl.empty        = (spec_cnt == '0);
  assign fl.err_overflow = err_q;

  // Next pointers and counts; a flush rewinds the speculative side onto the committed side
  always_comb begin
    head_next        = head;
    spec_cnt_next    = spec_cnt;
    commit_head_next = commit_head;
    commit_cnt_next  = commit_cnt;
    tail_next        = tail;

    if (fl.commit_alloc) begin
      commit_head_next = ptr_inc(commit_head);
    end
    if (do_free) begin
      tail_next = ptr_inc(tail);
    end

    if (do_free && !fl.commit_alloc) begin
      commit_cnt_next = commit_cnt + CNT_ONE;
    end else if (!do_free && fl.commit_alloc) begin
      commit_cnt_next = commit_cnt - CNT_ONE;
    end

    if (fl.flush) begin
      head_next     = commit_head_next;
      spec_cnt_next = commit_cnt_next;
    end else begin
      if (grant) begin
        head_next = ptr_inc(head);
      end
      if (do_free && !grant) begin
        spec_cnt_next = spec_cnt + CNT_ONE;
      end else if (!do_free && grant) begin
        spec_cnt_next = spec_cnt - CNT_ONE;
      end
    end
  end

  // Pointer, count and sticky error registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head        <= '0;
      commit_head <= '0;
      tail        <= '0;
      spec_cnt    <= CNT_FULL;
      commit_cnt  <= CNT_FULL;
      err_q       <= 1'b0;
    end else begin
      head        <= head_next;
      commit_head <= commit_head_next;
      tail        <= tail_next;
      spec_cnt    <= spec_cnt_next;
      commit_cnt  <= commit_cnt_next;
      err_q       <= err_q | overflow;
    end
  end

  // Tag storage: reset reloads the unmapped tags, accepted frees land at the tail
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo[i] <= PHY_WIDTH'(ARCH_REGS + i);
      end
    end else if (do_free) begin
      fifo[tail] <= fl.free_preg;
    end
  end
endmodule

// File: tb/tb_phys_reg_free_list.sv
// tb/tb_phys_reg_free_list.sv - vector table plus grant scoreboard for phys_reg_free_list
module tb_phys_reg_free_list;
  localparam int PHY_REGS  = 64;
  localparam int ARCH_REGS = 32;
  localparam int DEPTH     = 32;
  localparam int PHY_WIDTH = 6;
  localparam int CNT_WIDTH = 6;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  phys_reg_free_list_if #(.PHY_WIDTH(PHY_WIDTH), .CNT_WIDTH(CNT_WIDTH)) ifc ();

  phys_reg_free_list #(
    .PHY_REGS (PHY_REGS),
    .ARCH_REGS(ARCH_REGS),
    .DEPTH    (DEPTH),
    .PHY_WIDTH(PHY_WIDTH),
    .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .fl   (ifc.slave)
  );

  typedef struct {
    logic       rn, req, fv;
    logic [5:0] fp;
    logic       ca, fl, chk;
    logic       e_valid;
    logic [5:0] e_preg;
    logic [5:0] e_cnt;
    logic       e_empty, e_err;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [5:0] exp_q[$];
  vec_t vecs[18];

  function automatic vec_t v(input logic rn, req, fv, input logic [5:0] fp,
                             input logic ca, fl, chk, ev, input logic [5:0] ep, ec,
                             input logic ee, er);
    vec_t r;
    r.rn = rn; r.req = req; r.fv = fv; r.fp = fp; r.ca = ca; r.fl = fl; r.chk = chk;
    r.e_valid = ev; r.e_preg = ep; r.e_cnt = ec; r.e_empty = ee; r.e_err = er;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later, well before the rising edge.
  task automatic drive(input logic rn, ar, fv, input logic [5:0] fp, input logic ca, fl);
    @(negedge clk);
    rst_n            = rn;
    ifc.alloc_req    = ar;
    ifc.free_valid   = fv;
    ifc.free_preg    = fp;
    ifc.commit_alloc = ca;
    ifc.flush        = fl;
    #1;
  endtask

  task automatic sb_grant(input string nm);
    logic [5:0] e;
    check({nm, "_valid"}, {31'd0, ifc.alloc_valid}, 32'd1);
    if (ifc.alloc_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s_unexpected actual=%0d required=none", nm, ifc.alloc_preg);
      end else begin
        e = exp_q.pop_front();
        check({nm, "_preg"}, {26'd0, ifc.alloc_preg}, {26'd0, e});
      end
    end
  endtask

  task automatic reset_dut();
    drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
    exp_q.delete();
  endtask

  task automatic drain_from_reset(input string nm);
    for (int k = 0; k < DEPTH; k++) exp_q.push_back(6'(ARCH_REGS + k));
    for (int k = 0; k < DEPTH; k++) begin
      drive(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
      sb_grant(nm);
    end
  endtask

  initial begin
    rst_n            = 1'b0;
    ifc.alloc_req    = 1'b0;
    ifc.free_valid   = 1'b0;
    ifc.free_preg    = '0;
    ifc.commit_alloc = 1'b0;
    ifc.flush        = 1'b0;

    //              rn req fv fp ca fl chk  ev preg cnt emp err
    vecs[0]  = v(0, 0, 0, 0, 0, 0, 0,  0,  0,  0, 0, 0);
    vecs[1]  = v(1, 1, 0, 0, 0, 0, 1,  1, 32, 32, 0, 0);
    vecs[2]  = v(1, 1, 0, 0, 0, 0, 1,  1, 33, 31, 0, 0);
    vecs[3]  = v(1, 1, 0, 0, 0, 0, 1,  1, 34, 30, 0, 0);
    vecs[4]  = v(1, 0, 0, 0, 0, 0, 1,  0, 35, 29, 0, 0);
    vecs[5]  = v(0, 0, 0, 0, 0, 0, 0,  0,  0,  0, 0, 0);
    vecs[6]  = v(1, 1, 0, 0, 0, 0, 1,  1, 32, 32, 0, 0);
    vecs[7]  = v(1, 1, 0, 0, 0, 0, 1,  1, 33, 31, 0, 0);
    vecs[8]  = v(1, 1, 0, 0, 0, 0, 1,  1, 34, 30, 0, 0);
    vecs[9]  = v(1, 1, 0, 0, 0, 0, 1,  1, 35, 29, 0, 0);
    vecs[10] = v(1, 0, 0, 0, 1, 0, 1,  0, 36, 28, 0, 0);
    vecs[11] = v(1, 1, 0, 0, 0, 1, 1,  0, 36, 28, 0, 0);
    vecs[12] = v(1, 0, 0, 0, 0, 0, 1,  0, 33, 31, 0, 0);
    vecs[13] = v(1, 1, 1, 3, 0, 1, 1,  0, 33, 31, 0, 0);
    vecs[14] = v(1, 1, 0, 0, 0, 0, 1,  1, 33, 32, 0, 0);
    vecs[15] = v(1, 1, 0, 0, 0, 0, 1,  1, 34, 31, 0, 0);
    vecs[16] = v(1, 1, 0, 0, 1, 1, 1,  0, 35, 30, 0, 0);
    vecs[17] = v(1, 0, 0, 0, 0, 0, 1,  0, 34, 31, 0, 0);

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].rn, vecs[i].req, vecs[i].fv, vecs[i].fp, vecs[i].ca, vecs[i].fl);
      if (vecs[i].chk) begin
        check($sformatf("vec%0d_valid", i), {31'd0, ifc.alloc_valid}, {31'd0, vecs[i].e_valid});
        check($sformatf("vec%0d_preg", i), {26'd0, ifc.alloc_preg}, {26'd0, vecs[i].e_preg});
        check($sformatf("vec%0d_count", i), {26'd0, ifc.free_count}, {26'd0, vecs[i].e_cnt});
        check($sformatf("vec%0d_empty", i), {31'd0, ifc.empty}, {31'd0, vecs[i].e_empty});
        check($sformatf("vec%0d_err", i), {31'd0, ifc.err_overflow}, {31'd0, vecs[i].e_err});
      end
    end

    // Drain to empty, then hold the request
    reset_dut();
    drain_from_reset("t2_grant");
    drive(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
    check("t2_empty", {31'd0, ifc.empty}, 32'd1);
    check("t2_valid", {31'd0, ifc.alloc_valid}, 32'd0);
    check("t2_count", {26'd0, ifc.free_count}, 32'd0);

    // Free into an empty list: no bypass, tag granted the cycle after
    drive(1'b1, 1'b1, 1'b1, 6'd5, 1'b0, 1'b0);
    exp_q.push_back(6'd5);
    check("t3_nobypass", {31'd0, ifc.alloc_valid}, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
    sb_grant("t3_grant");

    // Head wraps on drain, tail wraps after a full refill, overflow free is dropped
    reset_dut();
    drain_from_reset("t5_drain");
    drive(1'b1, 1'b0, 1'b1, 6'd7, 1'b0, 1'b0);
    exp_q.push_back(6'd7);
    drive(1'b1, 1'b0, 1'b1, 6'd9, 1'b0, 1'b0);
    exp_q.push_back(6'd9);
    drive(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
    sb_grant("t5_wrap");
    drive(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
    sb_grant("t5_wrap");
    for (int k = 0; k < DEPTH; k++) begin
      drive(1'b1, 1'b0, 1'b1, 6'(10 + k), 1'b0, 1'b0);
      exp_q.push_back(6'(10 + k));
    end
    drive(1'b1, 1'b0, 1'b1, 6'd1, 1'b0, 1'b0);
    check("t5_full_count", {26'd0, ifc.free_count}, 32'd32);
    check("t5_err_pre", {31'd0, ifc.err_overflow}, 32'd0);
    for (int k = 0; k < DEPTH; k++) begin
      drive(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
      if (k == 0) begin
        check("t5_err_set", {31'd0, ifc.err_overflow}, 32'd1);
        check("t5_ovf_count", {26'd0, ifc.free_count}, 32'd32);
      end
      sb_grant("t5_refill");
    end

    // Reset mid-stream clears the sticky error and restores the initial list
    drive(1'b1, 1'b0, 1'b1, 6'd20, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 6'd21, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 6'd22, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
    exp_q.delete();
    drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
    check("t6_count", {26'd0, ifc.free_count}, 32'd32);
    check("t6_preg", {26'd0, ifc.alloc_preg}, 32'd32);
    check("t6_err_clr", {31'd0, ifc.err_overflow}, 32'd0);
    drive(1'b1, 1'b0, 1'b1, 6'd12, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
    check("t6_err_set", {31'd0, ifc.err_overflow}, 32'd1);
    check("t6_full_count", {26'd0, ifc.free_count}, 32'd32);
    check("t6_full_preg", {26'd0, ifc.alloc_preg}, 32'd32);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
